// File: rtl/irig_frame_decoder.sv
// IRIG-B DC level-shift symbol classifier and frame locker.
// Optional input glitch filter is enabled with `define IRIG_GLITCH_FILT_EN.
module irig_frame_decoder #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned T_MIN      = 10,
    parameter int unsigned T0_MAX     = 35,
    parameter int unsigned T1_MAX     = 65,
    parameter int unsigned TM_MAX     = 95,
    parameter int unsigned T_TIMEOUT  = 120,
    parameter int unsigned GLITCH_LEN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       irig_in,
    output logic       sym_valid,
    output logic [1:0] sym_type,
    output logic       frame_start,
    output logic [6:0] bit_pos,
    output logic       locked,
    output logic       sym_err
);

`ifdef IRIG_GLITCH_FILT_EN
    localparam int unsigned FILT_STAGES = GLITCH_LEN;
`else
    localparam int unsigned FILT_STAGES = 0;
`endif

    localparam logic [1:0] SYM_ZERO = 2'b00;
    localparam logic [1:0] SYM_ONE  = 2'b01;
    localparam logic [1:0] SYM_MARK = 2'b10;

    typedef enum logic [1:0] {HUNT, GOT1, LOCKED} state_t;

    state_t           state, state_n;
    logic             sync1, sync2, lvl, lvl_d;
    logic             fall_r, stuck_hi;
    logic [CNT_W-1:0] run_cnt, width_r;
    logic             tmo, sym_ok, w_err, is_mark, mark_exp;
    logic [1:0]       cls;
    logic [6:0]       nxt_pos, pos_n;
    logic [1:0]       type_n;
    logic             sv_n, fs_n, err_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= irig_in;
            sync2 <= sync1;
        end
    end

    generate
        if (FILT_STAGES > 0) begin : g_filt
            logic             filt;
            logic [CNT_W-1:0] fcnt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    filt <= 1'b0;
                    fcnt <= '0;
                end else if (sync2 == filt) begin
                    fcnt <= '0;
                end else if (fcnt >= CNT_W'(FILT_STAGES - 1)) begin
                    filt <= sync2;
                    fcnt <= '0;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
            assign lvl = filt;
        end else begin : g_nofilt
            assign lvl = sync2;
        end
    endgenerate

    // run_cnt counts cycles at the current level; on a fall it holds the high width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_d    <= 1'b0;
            fall_r   <= 1'b0;
            run_cnt  <= '0;
            width_r  <= '0;
            stuck_hi <= 1'b0;
        end else begin
            lvl_d  <= lvl;
            fall_r <= lvl_d & ~lvl;
            if (lvl != lvl_d)
                run_cnt <= CNT_W'(1);
            else if (run_cnt != '1)
                run_cnt <= run_cnt + 1'b1;
            if (lvl_d & ~lvl)
                width_r <= run_cnt;
            if (fall_r)
                stuck_hi <= 1'b0;
            else if (tmo && lvl)
                stuck_hi <= 1'b1;
        end
    end

    // Fires once per episode: the saturating counter passes this value only once.
    assign tmo    = (lvl == lvl_d) && (run_cnt == CNT_W'(T_TIMEOUT - 1));
    assign sym_ok = fall_r && !stuck_hi;
    assign w_err  = (width_r < CNT_W'(T_MIN)) || (width_r > CNT_W'(TM_MAX));

    always_comb begin
        cls = SYM_MARK;
        if (width_r <= CNT_W'(T0_MAX))
            cls = SYM_ZERO;
        else if (width_r <= CNT_W'(T1_MAX))
            cls = SYM_ONE;
    end

    assign is_mark  = (cls == SYM_MARK);
    assign nxt_pos  = (bit_pos == 7'd99) ? '0 : bit_pos + 7'd1;
    assign mark_exp = (nxt_pos == 7'd0) || ((nxt_pos % 7'd10) == 7'd9);

    always_comb begin
        state_n = state;
        pos_n   = bit_pos;
        type_n  = sym_type;
        sv_n    = 1'b0;
        fs_n    = 1'b0;
        err_n   = 1'b0;
        if (tmo || (sym_ok && w_err)) begin
            err_n   = 1'b1;
            state_n = HUNT;
        end else if (sym_ok) begin
            case (state)
                HUNT: begin
                    sv_n   = 1'b1;
                    type_n = cls;
                    if (is_mark)
                        state_n = GOT1;
                end
                GOT1: begin
                    sv_n   = 1'b1;
                    type_n = cls;
                    if (is_mark) begin
                        state_n = LOCKED;
                        pos_n   = '0;
                        fs_n    = 1'b1;
                    end else begin
                        state_n = HUNT;
                    end
                end
                LOCKED: begin
                    if (is_mark != mark_exp) begin
                        err_n   = 1'b1;
                        state_n = HUNT;
                        pos_n   = '0;
                    end else begin
                        sv_n   = 1'b1;
                        type_n = cls;
                        pos_n  = nxt_pos;
                        fs_n   = (nxt_pos == 7'd0);
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            bit_pos     <= '0;
            sym_type    <= SYM_ZERO;
            sym_valid   <= 1'b0;
            frame_start <= 1'b0;
            sym_err     <= 1'b0;
        end else begin
            state       <= state_n;
            bit_pos     <= pos_n;
            sym_type    <= type_n;
            sym_valid   <= sv_n;
            frame_start <= fs_n;
            sym_err     <= err_n;
        end
    end

    assign locked = (state == LOCKED);

endmodule
